// File: rtl/seven_seg_pkg.sv
// Shared constants and helpers for the seven-segment display paths.
// Segment patterns are active-high, bit order {g,f,e,d,c,b,a}.
package seven_seg_pkg;

  localparam int SEG_W = 7;

  // Segment bit positions inside a 7-bit pattern.
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // All segments dark (active-high view).
  localparam logic [SEG_W-1:0] SEG_OFF = 7'h00;

  // Standard hex glyphs 0..F; lower-case b and d keep them distinct from 8 and 0.
  localparam logic [SEG_W-1:0] SEG_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,   // 0 1 2 3
    7'h66, 7'h6D, 7'h7D, 7'h07,   // 4 5 6 7
    7'h7F, 7'h6F, 7'h77, 7'h7C,   // 8 9 A b
    7'h39, 7'h5E, 7'h79, 7'h71    // C d E F
  };

  // Width of a digit index able to address `digits` positions.
  function automatic int idx_width(input int digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational hex nibble to active-high segment decoder.
// Shared by every display path that needs the standard hex glyphs.
module seven_seg_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0]       nibble_i,
  output logic [SEG_W-1:0] seg_o
);

  // Table lookup; every nibble value has a glyph so no default path is needed.
  always_comb begin
    seg_o = SEG_HEX[nibble_i];
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed driver for a common-anode bank of DIGITS hex digits.
// Features: frame-latched inputs, per-digit blanking, decimal points,
// leading-zero suppression, dead time at the start of each digit slot.
// Optional PWM dimming is compiled in when SEVEN_SEG_DIM_EN is defined;
// without it dim_level is ignored and the PWM counter is not built.
module seven_seg_scanner #(
  parameter int DIGITS     = 4,
  parameter int DIV        = 50000,
  parameter int GUARD      = 8,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   displayed_num,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  input  logic                  lz_en,
  input  logic [3:0]            dim_level,
  output logic [6:0]            numberbox_out,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     anode_activate,
  output logic                  frame_tick
);

  import seven_seg_pkg::*;

  localparam int IDX_W = idx_width(DIGITS);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  // Pin levels that mean "off" for the selected polarity.
  localparam logic [DIGITS-1:0] ANODE_OFF   = {DIGITS{ACTIVE_LOW}};
  localparam logic [SEG_W-1:0]  SEG_PIN_OFF = ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
  localparam logic              DP_OFF      = ACTIVE_LOW;

  // ---------------------------------------------------------------------
  // Slot prescaler and digit index
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             slot_adv;
  logic             frame_bnd;

  // Next-state for the slot counter and digit index; frame boundary is the idx wrap.
  // NOTE: every variable written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    slot_adv   = (slot_cnt_q == CNT_W'(DIV - 1));
    frame_bnd  = slot_adv && (idx_q == IDX_W'(DIGITS - 1));
    slot_cnt_d = slot_adv ? '0 : slot_cnt_q + 1'b1;
    idx_d      = idx_q;
    if (slot_adv) begin
      idx_d = frame_bnd ? '0 : idx_q + 1'b1;
    end
  end

  // Counter state registers.
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_q <= '0;
      idx_q      <= '0;
    end else begin
      slot_cnt_q <= slot_cnt_d;
      idx_q      <= idx_d;
    end
  end

  // ---------------------------------------------------------------------
  // Frame-latched shadow copies of the display request
  // ---------------------------------------------------------------------
  logic [4*DIGITS-1:0] num_sh_q;
  logic [DIGITS-1:0]   dp_sh_q;
  logic [DIGITS-1:0]   blank_sh_q;
  logic                lz_sh_q;

  // Shadow load at the frame boundary only, so a frame never mixes old and new data.
  // NOTE: the shadow bank is reset (blank all ones) rather than left undefined, which
  // is what makes the first frame after reset deterministically dark.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_sh_q   <= '0;
      dp_sh_q    <= '0;
      blank_sh_q <= '1;
      lz_sh_q    <= 1'b0;
    end else if (frame_bnd) begin
      num_sh_q   <= displayed_num;
      dp_sh_q    <= dp_in;
      blank_sh_q <= blank_in;
      lz_sh_q    <= lz_en;
    end
  end

  // ---------------------------------------------------------------------
  // Optional PWM dimming
  // ---------------------------------------------------------------------
  logic pwm_gate;

`ifdef SEVEN_SEG_DIM_EN
  logic [3:0] dim_sh_q;
  logic [3:0] pwm_cnt_q;

  // Free-running PWM phase and frame-latched brightness.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q <= '0;
      dim_sh_q  <= 4'hF;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 4'd1;
      if (frame_bnd) begin
        dim_sh_q <= dim_level;
      end
    end
  end

  assign pwm_gate = (pwm_cnt_q <= dim_sh_q);
`else
  // Brightness input is accepted for pin compatibility but has no effect.
  logic unused_dim;
  assign unused_dim = ^dim_level;
  assign pwm_gate   = 1'b1;
`endif

  // ---------------------------------------------------------------------
  // Per-digit darkness: explicit blank or leading-zero suppression
  // ---------------------------------------------------------------------
  logic [DIGITS-1:0] dark;
  logic              zero_run;

  // Walk from the most significant digit down; zero_run stays set while every
  // nibble seen so far is zero. Digit 0 is never suppressed so "0" still shows.
  always_comb begin
    dark     = '0;
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (num_sh_q[4*i +: 4] == 4'h0);
      dark[i]  = blank_sh_q[i] || (lz_sh_q && zero_run && (i != 0));
    end
  end

  // ---------------------------------------------------------------------
  // Current-digit selection and decode
  // ---------------------------------------------------------------------
  logic [3:0]       cur_nib;
  logic             cur_dp;
  logic             cur_dark;
  logic [SEG_W-1:0] seg_dec;

  // Compare-based mux keeps an unreachable idx (non power-of-two DIGITS) in range.
  always_comb begin
    cur_nib  = '0;
    cur_dp   = 1'b0;
    cur_dark = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nib  = num_sh_q[4*i +: 4];
        cur_dp   = dp_sh_q[i];
        cur_dark = dark[i];
      end
    end
  end

  seven_seg_decoder u_decoder (
    .nibble_i (cur_nib),
    .seg_o    (seg_dec)
  );

  // ---------------------------------------------------------------------
  // Pin values (before the output register)
  // ---------------------------------------------------------------------
  logic [DIGITS-1:0] anode_d;
  logic [SEG_W-1:0]  seg_d;
  logic              dp_d;
  logic              frame_tick_d;
  logic              anode_on;
  logic [DIGITS-1:0] anode_act;

  // Enable only the selected digit, after the dead time, when lit and gated on;
  // polarity is applied as the very last step.
  always_comb begin
    anode_on  = !cur_dark && (slot_cnt_q >= CNT_W'(GUARD)) && pwm_gate;
    anode_act = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        anode_act[i] = anode_on;
      end
    end
    anode_d = ACTIVE_LOW ? ~anode_act : anode_act;
    seg_d   = ACTIVE_LOW ? ~seg_dec : seg_dec;
    dp_d    = ACTIVE_LOW ? ~(cur_dp && !cur_dark) : (cur_dp && !cur_dark);
    // Registered pulse lines up with the wrap cycle: raise it one cycle early.
    frame_tick_d = (slot_cnt_q == CNT_W'(DIV - 2)) && (idx_q == IDX_W'(DIGITS - 1));
  end

  // Output register: glitch-free pins, forced dark asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anode_activate <= ANODE_OFF;
      numberbox_out  <= SEG_PIN_OFF;
      dp_out         <= DP_OFF;
      frame_tick     <= 1'b0;
    end else begin
      anode_activate <= anode_d;
      numberbox_out  <= seg_d;
      dp_out         <= dp_d;
      frame_tick     <= frame_tick_d;
    end
  end

endmodule
